// File: rtl/mc_control_pkg.sv
// Shared encodings for the multicycle controller: states, opcodes, ALU and PC select codes,
// plus the packed control-word type used by the output decode.
package mc_control_pkg;

   typedef logic [3:0] state_t;

   localparam state_t ST_FETCH  = 4'd0;
   localparam state_t ST_DECODE = 4'd1;
   localparam state_t ST_EXEC_R = 4'd2;
   localparam state_t ST_WB_R   = 4'd3;
   localparam state_t ST_EXEC_I = 4'd4;
   localparam state_t ST_ADDR   = 4'd5;
   localparam state_t ST_MEM_RD = 4'd6;
   localparam state_t ST_MEM_WR = 4'd7;
   localparam state_t ST_WB_MEM = 4'd8;
   localparam state_t ST_BRANCH = 4'd9;
   localparam state_t ST_JUMP   = 4'd10;
   localparam state_t ST_HALT   = 4'd11;

   localparam logic [3:0] OP_R    = 4'd0;
   localparam logic [3:0] OP_ADDI = 4'd1;
   localparam logic [3:0] OP_LW   = 4'd2;
   localparam logic [3:0] OP_SW   = 4'd3;
   localparam logic [3:0] OP_BEQ  = 4'd4;
   localparam logic [3:0] OP_J    = 4'd5;
   localparam logic [3:0] OP_HALT = 4'd15;

   localparam logic [1:0] ALUOP_ADD  = 2'b00;
   localparam logic [1:0] ALUOP_SUB  = 2'b01;
   localparam logic [1:0] ALUOP_FUNC = 2'b10;

   localparam logic [1:0] PCSRC_ALU    = 2'b00;
   localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
   localparam logic [1:0] PCSRC_JUMP   = 2'b10;

   localparam logic [1:0] SRCB_REG  = 2'b00;
   localparam logic [1:0] SRCB_FOUR = 2'b01;
   localparam logic [1:0] SRCB_IMM  = 2'b10;
   localparam logic [1:0] SRCB_OFFS = 2'b11;

   typedef struct packed {
      logic       pc_write;
      logic       ir_write;
      logic       mem_write;
      logic       mem_read;
      logic       reg_write;
      logic       iord;
      logic       mem_to_reg;
      logic       alu_src_a;
      logic [1:0] alu_src_b;
      logic [1:0] alu_op;
      logic [1:0] pc_source;
   } ctrl_t;

endpackage

// File: rtl/mc_control.sv
// Multicycle datapath controller: Moore FSM whose only input-dependent outputs are the
// MemReady-qualified fetch strobes and the Zero-driven branch PC write.
module mc_control
   import mc_control_pkg::*;
#(
   parameter int unsigned OPW = 4
) (
   input  logic           CLK,
   input  logic           Reset,
   input  logic [OPW-1:0] Opcode,
   input  logic           Zero,
   input  logic           MemReady,
   output logic           PCWrite,
   output logic           IRWrite,
   output logic           MemWrite,
   output logic           MemRead,
   output logic           RegWrite,
   output logic           IorD,
   output logic           MemtoReg,
   output logic           ALUSrcA,
   output logic [1:0]     ALUSrcB,
   output logic [1:0]     ALUOp,
   output logic [1:0]     PCSource,
   output logic [3:0]     State
);

   state_t state_q, state_d;
   ctrl_t  ctrl;

   always_ff @(posedge CLK) begin
      if (Reset) state_q <= ST_FETCH;
      else       state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_FETCH:  if (MemReady) state_d = ST_DECODE;
         ST_DECODE: begin
            if      (Opcode == OPW'(OP_R))    state_d = ST_EXEC_R;
            else if (Opcode == OPW'(OP_ADDI)) state_d = ST_EXEC_I;
            else if (Opcode == OPW'(OP_LW))   state_d = ST_ADDR;
            else if (Opcode == OPW'(OP_SW))   state_d = ST_ADDR;
            else if (Opcode == OPW'(OP_BEQ))  state_d = ST_BRANCH;
            else if (Opcode == OPW'(OP_J))    state_d = ST_JUMP;
            else if (Opcode == OPW'(OP_HALT)) state_d = ST_HALT;
            else                              state_d = ST_FETCH;
         end
         ST_EXEC_R, ST_EXEC_I: state_d = ST_WB_R;
         ST_ADDR: begin
            // Opcode is re-sampled here; anything but a load/store falls back to fetch.
            if      (Opcode == OPW'(OP_LW)) state_d = ST_MEM_RD;
            else if (Opcode == OPW'(OP_SW)) state_d = ST_MEM_WR;
            else                            state_d = ST_FETCH;
         end
         ST_MEM_RD: if (MemReady) state_d = ST_WB_MEM;
         ST_MEM_WR: if (MemReady) state_d = ST_FETCH;
         ST_WB_R, ST_WB_MEM, ST_BRANCH, ST_JUMP: state_d = ST_FETCH;
         ST_HALT:   state_d = ST_HALT;
         default:   state_d = ST_FETCH;
      endcase
   end

   always_comb begin
      ctrl = '0;
      case (state_q)
         ST_FETCH: begin
            ctrl.mem_read  = 1'b1;
            ctrl.alu_src_b = SRCB_FOUR;
            ctrl.alu_op    = ALUOP_ADD;
            ctrl.pc_source = PCSRC_ALU;
            ctrl.ir_write  = MemReady;
            ctrl.pc_write  = MemReady;
         end
         ST_DECODE: ctrl.alu_src_b = SRCB_OFFS;
         ST_EXEC_R: begin
            ctrl.alu_src_a = 1'b1;
            ctrl.alu_src_b = SRCB_REG;
            ctrl.alu_op    = ALUOP_FUNC;
         end
         ST_EXEC_I, ST_ADDR: begin
            ctrl.alu_src_a = 1'b1;
            ctrl.alu_src_b = SRCB_IMM;
            ctrl.alu_op    = ALUOP_ADD;
         end
         ST_WB_R: ctrl.reg_write = 1'b1;
         ST_MEM_RD: begin
            ctrl.mem_read = 1'b1;
            ctrl.iord     = 1'b1;
         end
         ST_MEM_WR: begin
            ctrl.mem_write = 1'b1;
            ctrl.iord      = 1'b1;
         end
         ST_WB_MEM: begin
            ctrl.reg_write  = 1'b1;
            ctrl.mem_to_reg = 1'b1;
         end
         ST_BRANCH: begin
            ctrl.alu_src_a = 1'b1;
            ctrl.alu_src_b = SRCB_REG;
            ctrl.alu_op    = ALUOP_SUB;
            ctrl.pc_source = PCSRC_ALUOUT;
            ctrl.pc_write  = Zero;
         end
         ST_JUMP: begin
            ctrl.pc_source = PCSRC_JUMP;
            ctrl.pc_write  = 1'b1;
         end
         default: ctrl = '0;
      endcase
      // Reset masks every strobe combinationally so no write can coincide with it.
      if (Reset) ctrl = '0;
   end

   assign PCWrite  = ctrl.pc_write;
   assign IRWrite  = ctrl.ir_write;
   assign MemWrite = ctrl.mem_write;
   assign MemRead  = ctrl.mem_read;
   assign RegWrite = ctrl.reg_write;
   assign IorD     = ctrl.iord;
   assign MemtoReg = ctrl.mem_to_reg;
   assign ALUSrcA  = ctrl.alu_src_a;
   assign ALUSrcB  = ctrl.alu_src_b;
   assign ALUOp    = ctrl.alu_op;
   assign PCSource = ctrl.pc_source;
   assign State    = state_q;

endmodule

// File: tb/tb_mc_control.sv
// Directed bench for mc_control: walks every instruction class, memory stalls, branch taken and
// not taken, halt, undefined opcode and reset in the middle of a store.
module tb_mc_control;

   logic       CLK = 1'b0;
   logic       Reset;
   logic [3:0] Opcode;
   logic       Zero;
   logic       MemReady;
   logic       PCWrite, IRWrite, MemWrite, MemRead, RegWrite, IorD, MemtoReg, ALUSrcA;
   logic [1:0] ALUSrcB, ALUOp, PCSource;
   logic [3:0] State;

   int n_chk  = 0;
   int n_fail = 0;

   mc_control #(.OPW(4)) dut (
      .CLK      (CLK),
      .Reset    (Reset),
      .Opcode   (Opcode),
      .Zero     (Zero),
      .MemReady (MemReady),
      .PCWrite  (PCWrite),
      .IRWrite  (IRWrite),
      .MemWrite (MemWrite),
      .MemRead  (MemRead),
      .RegWrite (RegWrite),
      .IorD     (IorD),
      .MemtoReg (MemtoReg),
      .ALUSrcA  (ALUSrcA),
      .ALUSrcB  (ALUSrcB),
      .ALUOp    (ALUOp),
      .PCSource (PCSource),
      .State    (State)
   );

   always #5 CLK = ~CLK;

   // {PCWrite,IRWrite,MemWrite,MemRead,RegWrite,IorD,MemtoReg,ALUSrcA,ALUSrcB,ALUOp,PCSource}
   logic [13:0] obs;
   assign obs = {PCWrite, IRWrite, MemWrite, MemRead, RegWrite, IorD, MemtoReg, ALUSrcA,
                 ALUSrcB, ALUOp, PCSource};

   localparam logic [13:0] E_ZERO       = 14'b0;
   localparam logic [13:0] E_FETCH_WAIT = {8'b0001_0000, 2'b01, 2'b00, 2'b00};
   localparam logic [13:0] E_FETCH_RDY  = {8'b1101_0000, 2'b01, 2'b00, 2'b00};
   localparam logic [13:0] E_DECODE     = {8'b0000_0000, 2'b11, 2'b00, 2'b00};
   localparam logic [13:0] E_EXEC_R     = {8'b0000_0001, 2'b00, 2'b10, 2'b00};
   localparam logic [13:0] E_EXEC_I     = {8'b0000_0001, 2'b10, 2'b00, 2'b00};
   localparam logic [13:0] E_WB_R       = {8'b0000_1000, 2'b00, 2'b00, 2'b00};
   localparam logic [13:0] E_MEM_RD     = {8'b0001_0100, 2'b00, 2'b00, 2'b00};
   localparam logic [13:0] E_MEM_WR     = {8'b0010_0100, 2'b00, 2'b00, 2'b00};
   localparam logic [13:0] E_WB_MEM     = {8'b0000_1010, 2'b00, 2'b00, 2'b00};
   localparam logic [13:0] E_BR_NT      = {8'b0000_0001, 2'b00, 2'b01, 2'b01};
   localparam logic [13:0] E_BR_T       = {8'b1000_0001, 2'b00, 2'b01, 2'b01};
   localparam logic [13:0] E_JUMP       = {8'b1000_0000, 2'b00, 2'b00, 2'b10};

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic check(input string tag, input logic [3:0] es, input logic [13:0] ev);
      n_chk++;
      assert (State === es) else begin
         n_fail++;
         $error("FAIL %s state: got %0d expected %0d", tag, State, es);
      end
      n_chk++;
      assert (obs === ev) else begin
         n_fail++;
         $error("FAIL %s outputs: got %b expected %b", tag, obs, ev);
      end
   endtask

   initial begin
      Reset = 1'b1; Opcode = 4'd0; Zero = 1'b0; MemReady = 1'b1;

      tick(); check("reset1", 4'd0, E_ZERO);
      tick(); check("reset2", 4'd0, E_ZERO);
      Reset = 1'b0; #1;

      // R-type: 0,1,2,3,0
      check("r_fetch", 4'd0, E_FETCH_RDY);
      tick(); check("r_decode", 4'd1, E_DECODE);
      tick(); check("r_exec", 4'd2, E_EXEC_R);
      Opcode = 4'd15; // must be ignored outside DECODE/ADDR
      tick(); check("r_wb", 4'd3, E_WB_R);
      tick(); check("r_back", 4'd0, E_FETCH_RDY);

      // ADDI
      Opcode = 4'd1;
      tick(); check("i_decode", 4'd1, E_DECODE);
      tick(); check("i_exec", 4'd4, E_EXEC_I);
      tick(); check("i_wb", 4'd3, E_WB_R);
      tick(); check("i_back", 4'd0, E_FETCH_RDY);

      // Fetch stall
      MemReady = 1'b0; #1;
      check("fetch_wait", 4'd0, E_FETCH_WAIT);
      tick(); check("fetch_hold", 4'd0, E_FETCH_WAIT);
      MemReady = 1'b1; #1;
      check("fetch_go", 4'd0, E_FETCH_RDY);

      // LW with three not-ready cycles in MEM_RD
      Opcode = 4'd2;
      tick(); check("lw_decode", 4'd1, E_DECODE);
      tick(); check("lw_addr", 4'd5, E_EXEC_I);
      MemReady = 1'b0;
      tick(); check("lw_rd1", 4'd6, E_MEM_RD);
      tick(); check("lw_rd2", 4'd6, E_MEM_RD);
      tick(); check("lw_rd3", 4'd6, E_MEM_RD);
      MemReady = 1'b1; #1;
      check("lw_rd4", 4'd6, E_MEM_RD);
      tick(); check("lw_wb", 4'd8, E_WB_MEM);
      tick(); check("lw_back", 4'd0, E_FETCH_RDY);

      // SW
      Opcode = 4'd3;
      tick(); check("sw_decode", 4'd1, E_DECODE);
      tick(); check("sw_addr", 4'd5, E_EXEC_I);
      tick(); check("sw_wr", 4'd7, E_MEM_WR);
      tick(); check("sw_back", 4'd0, E_FETCH_RDY);

      // BEQ not taken, then taken
      Opcode = 4'd4; Zero = 1'b0;
      tick(); check("beq0_decode", 4'd1, E_DECODE);
      tick(); check("beq0_br", 4'd9, E_BR_NT);
      tick(); check("beq0_back", 4'd0, E_FETCH_RDY);
      Zero = 1'b1;
      tick(); check("beq1_decode", 4'd1, E_DECODE);
      tick(); check("beq1_br", 4'd9, E_BR_T);
      tick(); check("beq1_back", 4'd0, E_FETCH_RDY);
      Zero = 1'b0;

      // Jump
      Opcode = 4'd5;
      tick(); check("j_decode", 4'd1, E_DECODE);
      tick(); check("j_jump", 4'd10, E_JUMP);
      tick(); check("j_back", 4'd0, E_FETCH_RDY);

      // Undefined opcode is a NOP
      Opcode = 4'd7;
      tick(); check("nop_decode", 4'd1, E_DECODE);
      tick(); check("nop_back", 4'd0, E_FETCH_RDY);

      // Halt for 10 cycles, opcode wiggling, then reset out
      Opcode = 4'd15;
      tick(); check("halt_decode", 4'd1, E_DECODE);
      tick(); check("halt_enter", 4'd11, E_ZERO);
      for (int i = 0; i < 10; i++) begin
         Opcode = 4'(i);
         tick(); check("halt_hold", 4'd11, E_ZERO);
      end
      Reset = 1'b1; #1;
      check("halt_rst_pre", 4'd11, E_ZERO);
      tick(); check("halt_rst", 4'd0, E_ZERO);
      Reset = 1'b0; #1;
      check("halt_refetch", 4'd0, E_FETCH_RDY);

      // Reset in the middle of a stalled store
      Opcode = 4'd3;
      tick(); check("swr_decode", 4'd1, E_DECODE);
      tick(); check("swr_addr", 4'd5, E_EXEC_I);
      MemReady = 1'b0;
      tick(); check("swr_wr1", 4'd7, E_MEM_WR);
      tick(); check("swr_wr2", 4'd7, E_MEM_WR);
      Reset = 1'b1; #1;
      check("swr_rst_mask", 4'd7, E_ZERO);
      tick(); check("swr_rst", 4'd0, E_ZERO);
      Reset = 1'b0; MemReady = 1'b1; #1;
      check("swr_refetch", 4'd0, E_FETCH_RDY);
      tick(); check("swr_decode2", 4'd1, E_DECODE);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
